// File: rtl/negator_pkg.sv
// Shared types and default constants for the negator arbiter.
// Optional GAP cycle is enabled by NEGATOR_ARBITER_IDLE_GAP_EN (see negator_arbiter.sv).
package negator_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int LEN_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_i, wrapping.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [NREQ-1:0]  win_o,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             valid_o
);

  always_comb begin
    int idx;
    idx       = 0;
    win_o     = '0;
    win_idx_o = '0;
    valid_o   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_i) + k) % NREQ;
      if (!valid_o && req_i[IDX_W'(idx)]) begin
        valid_o   = 1'b1;
        win_o     = NREQ'(1) << idx;
        win_idx_o = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/negator_arbiter.sv
// Round-robin arbiter granting a shared toggling output for per-requester bursts.
// Define NEGATOR_ARBITER_IDLE_GAP_EN to insert one GAP cycle after every burst end.
module negator_arbiter
  import negator_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] len,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  out,
  output logic                  busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef NEGATOR_ARBITER_IDLE_GAP_EN
  localparam state_e END_ST = GAP;
`else
  localparam state_e END_ST = IDLE;
`endif

  state_e               state_q, state_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [NREQ-1:0]      done_q, done_d;
  logic                 out_q, out_d;
  logic                 busy_q;
  logic [LEN_W-1:0]     count_q, count_d;
  logic [IDX_W-1:0]     last_q, last_d;

  logic [NREQ-1:0]      win;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_valid;
  logic [NREQ*LEN_W-1:0] len_sh;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i     (req),
    .last_i    (last_q),
    .win_o     (win),
    .win_idx_o (win_idx),
    .valid_o   (win_valid)
  );

  assign len_sh = len >> (int'(win_idx) * LEN_W);

  // last_q doubles as the owner index while in RUN.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    out_d   = out_q;
    count_d = count_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          grant_d = win;
          count_d = len_sh[LEN_W-1:0];
          last_d  = win_idx;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!req[last_q] || (count_q == '0)) begin
          done_d  = grant_q;
          grant_d = '0;
          state_d = END_ST;
        end else begin
          out_d   = ~out_q;
          count_d = count_q - 1'b1;
          if (count_q == LEN_W'(1)) begin
            done_d  = grant_q;
            grant_d = '0;
            state_d = END_ST;
          end
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
      last_q  <= IDX_W'(NREQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      out_q   <= out_d;
      busy_q  <= (grant_d != '0);
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign out   = out_q;
  assign busy  = busy_q;

endmodule
